sram_bank_arbiter: RTL and testbench

Parametrised successor to the NPU's fixed 8-bank SRAM controller: arbitrates NUM_REQ generic requester ports onto NUM_BANKS single-port SRAM banks. It provides a valid/ready request handshake, per-bank fixed or round-robin priority, and in-order read-response routing back to the issuing requester with a parametrised bank read latency. It replaces hard-wired per-client ports (GEMM, ELEM, opN, AXI, result store) with a uniform indexed port array and adds saturating access/conflict statistics.

---
 rtl/sram_bank_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sram_bank_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_arbiter.sv
// sram_bank_arbiter: arbitrates NUM_REQ requester ports onto NUM_BANKS
// single-port SRAM banks. Each bank has its own winner selection, which is
// either fixed priority or round-robin. Read tags travel alongside the bank
// latency so that read data returns to the requester that issued it.
// Access and conflict counters saturate at their maximum value.
module sram_bank_arbiter #(
    parameter int NUM_REQ        = 8,
    parameter int NUM_BANKS      = 8,
    parameter int BANK_IDX_WIDTH = 3,
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 64,
    parameter int READ_LATENCY   = 1,
    parameter int RR_MODE        = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*BANK_IDX_WIDTH-1:0] req_bank,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_rdata,
    output logic [NUM_BANKS-1:0]             bank_en,
    output logic [NUM_BANKS-1:0]             bank_we,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0]  bank_addr,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]  bank_wdata,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]  bank_rdata,
    output logic [31:0]                      access_count,
    output logic [31:0]                      conflict_count,
    output logic                             bad_bank_err
);
    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_BANKS-1:0] grant_vld;
    logic [TAG_W-1:0]     grant_idx [NUM_BANKS];
    logic [NUM_BANKS-1:0] out_vld;
    logic [TAG_W-1:0]     out_tag [NUM_BANKS];
    logic [NUM_REQ-1:0]   bad_req;
    logic [NUM_REQ-1:0]   ready_raw;
    logic [NUM_REQ-1:0]   rsp_valid_next;
    logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata_next;
    logic [31:0]          access_inc;
    logic [31:0]          conflict_inc;
    logic [32:0]          access_sum;
    logic [32:0]          conflict_sum;

    // Requests aimed beyond the last bank are drained without touching any bank
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bad_req[i] = req_valid[i] &&
                         (int'(req_bank[i*BANK_IDX_WIDTH +: BANK_IDX_WIDTH]) >= NUM_BANKS);
        end
    end

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic [NUM_REQ-1:0]      cand;
        logic [TAG_W-1:0]        rr_ptr_reg;
        logic [TAG_W-1:0]        start;
        logic                    win_vld;
        logic [TAG_W-1:0]        win_idx;
        logic [READ_LATENCY-1:0] pipe_vld_reg;
        logic [TAG_W-1:0]        pipe_tag_reg [READ_LATENCY];

        // Candidates for this bank: valid requesters that select it
        always_comb begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand[i] = req_valid[i] &&
                          (int'(req_bank[i*BANK_IDX_WIDTH +: BANK_IDX_WIDTH]) == gi);
            end
        end

        assign start = (RR_MODE != 0) ? rr_ptr_reg : '0;

        // Search from start upward with wrap; scanning backwards leaves the first hit
        always_comb begin
            int idx;
            win_vld = 1'b0;
            win_idx = '0;
            idx     = 0;
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = int'(start) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (cand[idx]) begin
                    win_vld = 1'b1;
                    win_idx = TAG_W'(idx);
                end
            end
        end

        // Round-robin pointer moves just past the winner whenever the bank is granted
        always_ff @(posedge clk) begin
            if (rst) begin
                rr_ptr_reg <= '0;
            end else if (win_vld) begin
                rr_ptr_reg <= (win_idx == TAG_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
        end

        assign grant_vld[gi] = win_vld;
        assign grant_idx[gi] = win_idx;
        assign bank_en[gi]   = win_vld && !rst;
        assign bank_we[gi]   = bank_en[gi] && req_we[win_idx];
        assign bank_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] =
            bank_en[gi] ? req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        assign bank_wdata[gi*DATA_WIDTH +: DATA_WIDTH] =
            bank_en[gi] ? req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;

        // Read tags follow the bank latency; the last stage lines up with bank_rdata
        always_ff @(posedge clk) begin
            if (rst) begin
                pipe_vld_reg <= '0;
                for (int s = 0; s < READ_LATENCY; s++) begin
                    pipe_tag_reg[s] <= '0;
                end
            end else begin
                pipe_vld_reg[0] <= win_vld && !req_we[win_idx];
                pipe_tag_reg[0] <= win_idx;
                for (int s = 1; s < READ_LATENCY; s++) begin
                    pipe_vld_reg[s] <= pipe_vld_reg[s-1];
                    pipe_tag_reg[s] <= pipe_tag_reg[s-1];
                end
            end
        end

        assign out_vld[gi] = pipe_vld_reg[READ_LATENCY-1];
        assign out_tag[gi] = pipe_tag_reg[READ_LATENCY-1];
    end

    // Ready covers granted requesters plus drained out-of-range requests
    always_comb begin
        ready_raw = bad_req;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (grant_vld[b]) begin
                ready_raw[grant_idx[b]] = 1'b1;
            end
        end
    end

    assign req_ready = rst ? '0 : ready_raw;

    // Route emerging read data; banks are scanned downward so the lowest bank wins a collision
    always_comb begin
        rsp_valid_next = '0;
        rsp_rdata_next = '0;
        for (int b = NUM_BANKS - 1; b >= 0; b--) begin
            if (out_vld[b]) begin
                rsp_valid_next[out_tag[b]] = 1'b1;
                rsp_rdata_next[int'(out_tag[b])*DATA_WIDTH +: DATA_WIDTH] =
                    bank_rdata[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Per-cycle increments: granted banks, and valid in-range requesters left waiting
    always_comb begin
        access_inc   = '0;
        conflict_inc = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            access_inc = access_inc + 32'(grant_vld[b]);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            conflict_inc = conflict_inc + 32'(req_valid[i] && !bad_req[i] && !ready_raw[i]);
        end
    end

    assign access_sum   = {1'b0, access_count} + {1'b0, access_inc};
    assign conflict_sum = {1'b0, conflict_count} + {1'b0, conflict_inc};

    // Registered responses, saturating statistics and sticky bad-bank flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid      <= '0;
            rsp_rdata      <= '0;
            access_count   <= '0;
            conflict_count <= '0;
            bad_bank_err   <= 1'b0;
        end else begin
            rsp_valid      <= rsp_valid_next;
            rsp_rdata      <= rsp_rdata_next;
            access_count   <= access_sum[32] ? '1 : access_sum[31:0];
            conflict_count <= conflict_sum[32] ? '1 : conflict_sum[31:0];
            if (|bad_req) begin
                bad_bank_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Bench for sram_bank_arbiter: two instances share the request inputs.
// Instance A: 8 banks, latency 1, round-robin. Instance B: 4 banks, latency 3,
// fixed priority. Whichever instance is not under test is held in reset.
module tb_sram_bank_arbiter;
    localparam int NR = 8, BW = 3, AW = 12, DW = 64;
    localparam int NB_A = 8, RL_A = 1, NB_B = 4, RL_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_a, rst_b;
    logic [NR-1:0]    req_valid, req_we;
    logic [NR*BW-1:0] req_bank;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;

    logic [NR-1:0]      req_ready_a, rsp_valid_a;
    logic [NR*DW-1:0]   rsp_rdata_a;
    logic [NB_A-1:0]    bank_en_a, bank_we_a;
    logic [NB_A*AW-1:0] bank_addr_a;
    logic [NB_A*DW-1:0] bank_wdata_a, bank_rdata_a;
    logic [31:0]        access_a, conflict_a;
    logic               bad_a;

    logic [NR-1:0]      req_ready_b, rsp_valid_b;
    logic [NR*DW-1:0]   rsp_rdata_b;
    logic [NB_B-1:0]    bank_en_b, bank_we_b;
    logic [NB_B*AW-1:0] bank_addr_b;
    logic [NB_B*DW-1:0] bank_wdata_b, bank_rdata_b;
    logic [31:0]        access_b, conflict_b;
    logic               bad_b;

    sram_bank_arbiter #(.NUM_REQ(NR), .NUM_BANKS(NB_A), .BANK_IDX_WIDTH(BW), .ADDR_WIDTH(AW),
                        .DATA_WIDTH(DW), .READ_LATENCY(RL_A), .RR_MODE(1)) u_a (
        .clk(clk), .rst(rst_a), .req_valid(req_valid), .req_ready(req_ready_a), .req_we(req_we),
        .req_bank(req_bank), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .bank_en(bank_en_a), .bank_we(bank_we_a),
        .bank_addr(bank_addr_a), .bank_wdata(bank_wdata_a), .bank_rdata(bank_rdata_a),
        .access_count(access_a), .conflict_count(conflict_a), .bad_bank_err(bad_a));

    sram_bank_arbiter #(.NUM_REQ(NR), .NUM_BANKS(NB_B), .BANK_IDX_WIDTH(BW), .ADDR_WIDTH(AW),
                        .DATA_WIDTH(DW), .READ_LATENCY(RL_B), .RR_MODE(0)) u_b (
        .clk(clk), .rst(rst_b), .req_valid(req_valid), .req_ready(req_ready_b), .req_we(req_we),
        .req_bank(req_bank), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .bank_en(bank_en_b), .bank_we(bank_we_b),
        .bank_addr(bank_addr_b), .bank_wdata(bank_wdata_b), .bank_rdata(bank_rdata_b),
        .access_count(access_b), .conflict_count(conflict_b), .bad_bank_err(bad_b));

    function automatic logic [63:0] init_word(input int inst, input int b, input int a);
        return 64'hB000_0000_0000_0000 | (64'(inst) << 48) | (64'(b) << 32) | 64'(a);
    endfunction

    // SRAM models: preloaded on the first edge, then driven only by the DUT bank ports
    logic [DW-1:0] mem_a [NB_A][256];
    logic [DW-1:0] rdp_a [NB_A];
    logic [DW-1:0] mem_b [NB_B][256];
    logic [DW-1:0] rdp_b [NB_B][RL_B];

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int b = 0; b < NB_A; b++)
                for (int a = 0; a < 256; a++) mem_a[b][a] <= init_word(0, b, a);
            mem_a[3][5] <= 64'hA5A5;
        end else begin
            for (int b = 0; b < NB_A; b++) begin
                if (bank_en_a[b]) begin
                    if (bank_we_a[b]) mem_a[b][bank_addr_a[b*AW +: 8]] <= bank_wdata_a[b*DW +: DW];
                    else rdp_a[b] <= mem_a[b][bank_addr_a[b*AW +: 8]];
                end
            end
        end
    end

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int b = 0; b < NB_B; b++)
                for (int a = 0; a < 256; a++) mem_b[b][a] <= init_word(1, b, a);
            mem_b[3][5] <= 64'hA5A5;
        end else begin
            for (int b = 0; b < NB_B; b++) begin
                for (int s = RL_B - 1; s > 0; s--) rdp_b[b][s] <= rdp_b[b][s-1];
                if (bank_en_b[b]) begin
                    if (bank_we_b[b]) mem_b[b][bank_addr_b[b*AW +: 8]] <= bank_wdata_b[b*DW +: DW];
                    else rdp_b[b][0] <= mem_b[b][bank_addr_b[b*AW +: 8]];
                end
            end
        end
    end

    always_comb begin
        bank_rdata_a = '0;
        bank_rdata_b = '0;
        for (int b = 0; b < NB_A; b++) bank_rdata_a[b*DW +: DW] = rdp_a[b];
        for (int b = 0; b < NB_B; b++) bank_rdata_b[b*DW +: DW] = rdp_b[b][RL_B-1];
    end

    // Scoreboard and reference memory
    typedef struct { int inst; int req; logic [63:0] data; int due; } exp_t;
    exp_t sb[$];
    logic [63:0] ref_mem [2][8][256];
    int act;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Response monitor: every cycle, compare both instances against due scoreboard entries
    always @(negedge clk) begin
        logic [NR-1:0] ev;
        logic [63:0]   ed [NR];
        for (int inst = 0; inst < 2; inst++) begin
            ev = '0;
            for (int r = 0; r < NR; r++) ed[r] = '0;
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].inst == inst && sb[k].due == cyc) begin
                    ev[sb[k].req] = 1'b1;
                    ed[sb[k].req] = sb[k].data;
                    sb.delete(k);
                end
            end
            chk(inst == 0 ? "rsp_valid_a" : "rsp_valid_b", inst == 0 ? rsp_valid_a : rsp_valid_b, ev);
            for (int r = 0; r < NR; r++) begin
                if (ev[r]) begin
                    chk($sformatf("rsp_rdata inst%0d req%0d", inst, r),
                        inst == 0 ? rsp_rdata_a[r*DW +: DW] : rsp_rdata_b[r*DW +: DW], ed[r]);
                    $display("rsp inst%0d req%0d data %h at cycle %0d", inst, r, ed[r], cyc);
                end
            end
        end
    end

    task automatic clear_reqs();
        req_valid = '0; req_we = '0; req_bank = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int r, input logic we, input int bank, input int addr,
                           input logic [63:0] wd);
        req_valid[r] = 1'b1;
        req_we[r] = we;
        req_bank[r*BW +: BW] = BW'(bank);
        req_addr[r*AW +: AW] = AW'(addr);
        req_wdata[r*DW +: DW] = wd;
    endtask

    // Record accepted transfers of the active instance into ref memory / scoreboard
    task automatic account();
        logic [NR-1:0] rdy;
        int nb, rl, b, a;
        rdy = (act == 0) ? req_ready_a : req_ready_b;
        nb  = (act == 0) ? NB_A : NB_B;
        rl  = (act == 0) ? RL_A : RL_B;
        for (int r = 0; r < NR; r++) begin
            if (req_valid[r] && rdy[r]) begin
                b = int'(req_bank[r*BW +: BW]);
                a = int'(req_addr[r*AW +: 8]);
                if (b < nb) begin
                    if (req_we[r]) ref_mem[act][b][a] = req_wdata[r*DW +: DW];
                    else sb.push_back('{act, r, ref_mem[act][b][a], cyc + rl + 1});
                end
            end
        end
    endtask

    task automatic end_cycle();
        account();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        clear_reqs();
        repeat (n) begin
            @(negedge clk);
            end_cycle();
        end
    endtask

    task automatic flush_sb(input int inst);
        for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].inst == inst) sb.delete(k);
    endtask

    typedef struct {
        logic [7:0] valid; logic [7:0] we; logic [23:0] bank; int base;
        logic [7:0] exp_ready; logic [7:0] exp_en; logic [7:0] exp_bwe;
    } vec_t;
    vec_t tbl [5];
    logic [7:0] rr_valid [6];
    logic [7:0] rr_exp [6];

    initial begin
        for (int i = 0; i < 2; i++)
            for (int b = 0; b < 8; b++)
                for (int a = 0; a < 256; a++) ref_mem[i][b][a] = init_word(i, b, a);
        ref_mem[0][3][5] = 64'hA5A5;
        ref_mem[1][3][5] = 64'hA5A5;

        // Instance A table: parallel write, parallel readback, single read, conflict, idle
        tbl[0] = '{8'hFF, 8'hFF, 24'o01234567, 'h40, 8'hFF, 8'hFF, 8'hFF};
        tbl[1] = '{8'hFF, 8'h00, 24'o01234567, 'h40, 8'hFF, 8'hFF, 8'h00};
        tbl[2] = '{8'h04, 8'h00, 24'o00000300, 3,    8'h04, 8'h08, 8'h00};
        tbl[3] = '{8'hE0, 8'hA0, 24'o22000000, 'h60, 8'h60, 8'h05, 8'h01};
        tbl[4] = '{8'h00, 8'h00, 24'o00000000, 0,    8'h00, 8'h00, 8'h00};
        rr_valid = '{8'h52, 8'h50, 8'h40, 8'h02, 8'h09, 8'h01};
        rr_exp   = '{8'h02, 8'h10, 8'h40, 8'h02, 8'h08, 8'h01};

        act = 0; rst_a = 1'b1; rst_b = 1'b1;
        clear_reqs();
        req_valid = '1;
        @(negedge clk);
        chk("reset ready_a", req_ready_a, 0);
        chk("reset bank_en_a", bank_en_a, 0);
        chk("reset ready_b", req_ready_b, 0);
        chk("reset bank_en_b", bank_en_b, 0);
        @(posedge clk); #1;
        clear_reqs();
        rst_a = 1'b0;
        @(negedge clk);
        chk("reset access_a", access_a, 0);
        chk("reset conflict_a", conflict_a, 0);
        chk("reset bad_a", bad_a, 0);
        end_cycle();

        for (int vi = 0; vi < 5; vi++) begin
            clear_reqs();
            for (int r = 0; r < NR; r++) begin
                if (tbl[vi].valid[r])
                    set_req(r, tbl[vi].we[r], int'(tbl[vi].bank[r*BW +: BW]), tbl[vi].base + r,
                            {8'hD0, 8'(vi), 8'(r), 8'h00, 32'hCAFE_0000 + 32'(r)});
            end
            @(negedge clk);
            $display("vec %0d: valid %h we %h -> ready %h bank_en %h", vi, req_valid, req_we,
                     req_ready_a, bank_en_a);
            chk($sformatf("v%0d req_ready", vi), req_ready_a, tbl[vi].exp_ready);
            chk($sformatf("v%0d bank_en", vi), bank_en_a, tbl[vi].exp_en);
            chk($sformatf("v%0d bank_we", vi), bank_we_a, tbl[vi].exp_bwe);
            end_cycle();
        end
        idle(3);
        @(negedge clk);
        chk("table access_a", access_a, 19);
        chk("table conflict_a", conflict_a, 1);
        end_cycle();

        // Reset one cycle after a read grant on A: the response must never appear
        clear_reqs();
        set_req(5, 1'b0, 0, 'h30, '0);
        @(negedge clk);
        chk("midread ready_a", req_ready_a, 8'h20);
        end_cycle();
        rst_a = 1'b1;
        flush_sb(0);
        clear_reqs();
        @(negedge clk);
        end_cycle();
        rst_a = 1'b0;
        idle(3);
        @(negedge clk);
        chk("post-reset access_a", access_a, 0);
        chk("post-reset conflict_a", conflict_a, 0);
        end_cycle();

        // Round-robin on bank 0: pointer restarts at 0 after reset
        for (int s = 0; s < 6; s++) begin
            clear_reqs();
            for (int r = 0; r < NR; r++) if (rr_valid[s][r]) set_req(r, 1'b0, 0, 'h20 + r, '0);
            @(negedge clk);
            $display("rr step %0d: valid %h -> ready %h", s, req_valid, req_ready_a);
            chk($sformatf("rr%0d req_ready", s), req_ready_a, rr_exp[s]);
            chk($sformatf("rr%0d bank_en", s), bank_en_a, 8'h01);
            end_cycle();
        end
        idle(3);
        @(negedge clk);
        chk("rr access_a", access_a, 6);
        chk("rr conflict_a", conflict_a, 4);
        end_cycle();

        // Switch to instance B
        rst_a = 1'b1;
        rst_b = 1'b0;
        act = 1;
        idle(1);
        @(negedge clk);
        chk("reset access_b", access_b, 0);
        chk("reset bad_b", bad_b, 0);
        end_cycle();

        // Fixed priority: reqs 1,4,6 hold bank 0 for three cycles, req 1 wins each time
        clear_reqs();
        set_req(1, 1'b0, 0, 'h11, '0);
        set_req(4, 1'b0, 0, 'h14, '0);
        set_req(6, 1'b0, 0, 'h16, '0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            $display("fixed cycle %0d: ready %h bank_en %h", c, req_ready_b, bank_en_b);
            chk($sformatf("fixed%0d req_ready", c), req_ready_b, 8'h02);
            chk($sformatf("fixed%0d bank_en", c), bank_en_b, 4'h1);
            end_cycle();
        end
        idle(5);
        @(negedge clk);
        chk("fixed conflict_b", conflict_b, 6);
        chk("fixed access_b", access_b, 3);
        end_cycle();

        // Out-of-range bank 5 is drained alongside a normal read to bank 1
        clear_reqs();
        set_req(2, 1'b0, 5, 'h22, '0);
        set_req(3, 1'b0, 1, 'h13, '0);
        @(negedge clk);
        chk("bad req_ready", req_ready_b, 8'h0C);
        chk("bad bank_en", bank_en_b, 4'h2);
        end_cycle();
        idle(1);
        @(negedge clk);
        chk("bad_bank_err set", bad_b, 1);
        chk("bad conflict_b", conflict_b, 6);
        chk("bad access_b", access_b, 4);
        end_cycle();
        idle(4);
        @(negedge clk);
        chk("bad_bank_err sticky", bad_b, 1);
        chk("bad_a untouched", bad_a, 0);
        end_cycle();

        // Reset one cycle after a read grant on B (latency 3)
        clear_reqs();
        set_req(0, 1'b0, 2, 'h12, '0);
        @(negedge clk);
        chk("midread ready_b", req_ready_b, 8'h01);
        end_cycle();
        rst_b = 1'b1;
        flush_sb(1);
        clear_reqs();
        @(negedge clk);
        end_cycle();
        rst_b = 1'b0;
        idle(6);
        @(negedge clk);
        chk("post-reset access_b", access_b, 0);
        chk("post-reset conflict_b", conflict_b, 0);
        chk("post-reset bad_b", bad_b, 0);
        chk("post-reset rsp_rdata_b", rsp_rdata_b[63:0], 0);
        end_cycle();

        // Single read: req 2, bank 3, addr 5 holds 0xA5A5
        clear_reqs();
        set_req(2, 1'b0, 3, 5, '0);
        @(negedge clk);
        chk("single req_ready", req_ready_b, 8'h04);
        chk("single bank_en", bank_en_b, 4'h8);
        chk("single bank_addr", bank_addr_b[3*AW +: AW], 5);
        end_cycle();
        idle(6);
        @(negedge clk);
        chk("single access_b", access_b, 1);
        chk("scoreboard drained", 64'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
